// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-ported register file.
package rf_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
   localparam int unsigned A0_IDX             = 10;
   localparam int unsigned ZERO_IDX           = 0;

   typedef logic [ADDR_WIDTH_DEFAULT-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by decode claims, cleared by writeback writes.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned NUM_WR     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_WR-1:0]            write_enable,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
   input  logic                         claim_valid,
   input  logic [ADDR_WIDTH-1:0]        claim_addr,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
   output logic [NUM_RD-1:0]            stored_busy
);

   localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;

   // Writes retire producers first; a same-edge claim names a newer producer and wins.
   always_comb begin
      pending_next = pending;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
         if (write_enable[w] &&
             write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_IDX)) begin
            pending_next[write_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (claim_valid && claim_addr != ADDR_WIDTH'(ZERO_IDX)) begin
         pending_next[claim_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   always_comb begin
      stored_busy = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         stored_busy[r] = pending[read_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with fixed-priority writes, optional write bypass
// and a RAW pending scoreboard for decode.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned NUM_WR     = 2,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_WR-1:0]            write_enable,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
   output logic [NUM_RD-1:0]            read_busy,
   input  logic                         claim_valid,
   input  logic [ADDR_WIDTH-1:0]        claim_addr,
   output logic [DATA_WIDTH-1:0]        a0
);

   localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_RD-1:0]     stored_busy;

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_RD     (NUM_RD),
      .NUM_WR     (NUM_WR)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .claim_valid  (claim_valid),
      .claim_addr   (claim_addr),
      .read_addr    (read_addr),
      .stored_busy  (stored_busy)
   );

   // Later ports are assigned last, so the highest-index port wins a collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (write_enable[w] &&
                write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_IDX)) begin
               regs[write_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Read muxes: stored value, overridden by the highest-index live write when bypassing.
   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         if (read_addr[r*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(ZERO_IDX)) begin
            read_data[r*DATA_WIDTH +: DATA_WIDTH] = regs[read_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            read_busy[r] = stored_busy[r];
            if (BYPASS != 0) begin
               for (int unsigned w = 0; w < NUM_WR; w++) begin
                  if (write_enable[w] &&
                      write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == read_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
                     read_data[r*DATA_WIDTH +: DATA_WIDTH] = write_data[w*DATA_WIDTH +: DATA_WIDTH];
                     read_busy[r] = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign a0 = regs[ADDR_WIDTH'(A0_IDX)];

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and a behavioural model.
module tb_reg_file_mp;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    write_enable;
   logic [2*AW-1:0] write_addr;
   logic [2*DW-1:0] write_data;
   logic [2*AW-1:0] read_addr;
   logic          claim_valid;
   logic [AW-1:0] claim_addr;

   logic [2*DW-1:0] rd_b, rd_n;
   logic [1:0]      busy_b, busy_n;
   logic [DW-1:0]   a0_b, a0_n;

   int total = 0;
   int bad   = 0;

   reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
      .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr(read_addr), .read_data(rd_b), .read_busy(busy_b),
      .claim_valid(claim_valid), .claim_addr(claim_addr), .a0(a0_b));

   reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr(read_addr), .read_data(rd_n), .read_busy(busy_n),
      .claim_valid(claim_valid), .claim_addr(claim_addr), .a0(a0_n));

   always #5 clk = ~clk;

   // Behavioural model: plain arrays of register contents and pending flags.
   logic [DW-1:0] m_mem [32];
   bit            m_pend [32];

   initial begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      end else begin
         for (int w = 0; w < 2; w++) begin
            int a;
            a = int'(write_addr[w*AW +: AW]);
            if (write_enable[w] && a != 0) begin
               m_mem[a]  = write_data[w*DW +: DW];
               m_pend[a] = 0;
            end
         end
         if (claim_valid && claim_addr != 0) m_pend[int'(claim_addr)] = 1;
      end
   end

   function automatic logic [DW-1:0] exp_data(input bit byp, input int r);
      int a;
      logic [DW-1:0] v;
      a = int'(read_addr[r*AW +: AW]);
      if (a == 0) return '0;
      v = m_mem[a];
      if (byp) begin
         for (int w = 0; w < 2; w++)
            if (write_enable[w] && int'(write_addr[w*AW +: AW]) == a) v = write_data[w*DW +: DW];
      end
      return v;
   endfunction

   function automatic logic exp_busy(input bit byp, input int r);
      int a;
      a = int'(read_addr[r*AW +: AW]);
      if (a == 0) return 1'b0;
      if (byp) begin
         for (int w = 0; w < 2; w++)
            if (write_enable[w] && int'(write_addr[w*AW +: AW]) == a) return 1'b0;
      end
      return m_pend[a];
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every mid-cycle: compare both instances against the model.
   always @(negedge clk) begin
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("byp_rd%0d", r),   rd_b[r*DW +: DW], exp_data(1, r));
         chk($sformatf("nobyp_rd%0d", r), rd_n[r*DW +: DW], exp_data(0, r));
         chk($sformatf("byp_busy%0d", r),   DW'(busy_b[r]), DW'(exp_busy(1, r)));
         chk($sformatf("nobyp_busy%0d", r), DW'(busy_n[r]), DW'(exp_busy(0, r)));
      end
      chk("byp_a0",   a0_b, m_mem[10]);
      chk("nobyp_a0", a0_n, m_mem[10]);
   end

   task automatic idle();
      write_enable = '0; write_addr = '0; write_data = '0;
      claim_valid = 1'b0; claim_addr = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] d);
      write_enable[p] = 1'b1;
      write_addr[p*AW +: AW] = AW'(a);
      write_data[p*DW +: DW] = d;
   endtask

   task automatic rdaddr(input int a0i, input int a1i);
      read_addr = {AW'(a1i), AW'(a0i)};
   endtask

   initial begin
      reset = 1'b1;
      idle();
      rdaddr(5, 10);
      cyc(); cyc();
      reset = 1'b0;
      #2;
      chk("rst_rd0", rd_b[DW-1:0], 32'h0);
      chk("rst_rd1", rd_n[2*DW-1:DW], 32'h0);
      chk("rst_busy", DW'(busy_b | busy_n), 32'h0);
      chk("rst_a0", a0_b | a0_n, 32'h0);
      cyc();

      // Write collision on x10: port 1 wins.
      wr(0, 10, 32'h1234); wr(1, 10, 32'hABCD);
      cyc(); idle(); #2;
      chk("coll_a0_b", a0_b, 32'hABCD);
      chk("coll_a0_n", a0_n, 32'hABCD);
      chk("coll_rd1", rd_n[2*DW-1:DW], 32'hABCD);
      cyc();

      // Bypass vs stored read.
      rdaddr(7, 10);
      wr(0, 7, 32'h55); #2;
      chk("byp_same_cyc", rd_b[DW-1:0], 32'h55);
      chk("nobyp_same_cyc", rd_n[DW-1:0], 32'h0);
      cyc(); idle(); #2;
      chk("nobyp_next_cyc", rd_n[DW-1:0], 32'h55);
      cyc();

      // Claim / clear / supersede on x3.
      claim_valid = 1'b1; claim_addr = AW'(3);
      cyc(); idle(); rdaddr(3, 0); #2;
      chk("claim_busy_b", DW'(busy_b[0]), 32'h1);
      chk("claim_busy_n", DW'(busy_n[0]), 32'h1);
      cyc();
      wr(1, 3, 32'h99); #2;
      chk("wb_byp_busy", DW'(busy_b[0]), 32'h0);
      chk("wb_nobyp_busy", DW'(busy_n[0]), 32'h1);
      chk("wb_nobyp_rd", rd_n[DW-1:0], 32'h0);
      cyc(); idle(); #2;
      chk("clr_busy", DW'(busy_n[0]), 32'h0);
      chk("clr_rd", rd_n[DW-1:0], 32'h99);
      cyc();
      claim_valid = 1'b1; claim_addr = AW'(3); wr(0, 3, 32'h77);
      cyc(); idle(); #2;
      chk("super_busy", DW'(busy_b[0] & busy_n[0]), 32'h1);
      chk("super_rd", rd_b[DW-1:0], 32'h77);
      cyc();

      // Writes and claims to x0 are ignored.
      rdaddr(0, 0);
      wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF);
      claim_valid = 1'b1; claim_addr = '0; #2;
      chk("x0_byp_rd", rd_b[DW-1:0], 32'h0);
      cyc(); idle(); #2;
      chk("x0_rd", rd_b[DW-1:0] | rd_n[2*DW-1:DW], 32'h0);
      chk("x0_busy", DW'(busy_b | busy_n), 32'h0);

      // Directed pattern sweep checked by the per-cycle model compare.
      for (int i = 0; i < 48; i++) begin
         idle();
         if (i % 3 != 0) wr(0, (i * 7) % 32, 32'h1000_0000 + 32'(i));
         if (i % 4 == 1) wr(1, (i * 7) % 32, 32'h2000_0000 + 32'(i));
         else if (i % 5 == 2) wr(1, (i * 11) % 32, 32'h3000_0000 + 32'(i));
         claim_valid = (i % 2 == 0);
         claim_addr  = AW'((i * 13) % 32);
         rdaddr((i * 7) % 32, (i * 13 + 5) % 32);
         cyc();
      end
      idle();

      // Mid-stream asynchronous reset with x3 pending and x10 populated.
      wr(0, 10, 32'hABCD); claim_valid = 1'b1; claim_addr = AW'(3);
      cyc(); idle(); rdaddr(3, 10); #2;
      chk("pre_rst_busy", DW'(busy_b[0]), 32'h1);
      chk("pre_rst_a0", a0_b, 32'hABCD);
      reset = 1'b1; #1;
      chk("mid_rst_busy", DW'(busy_b | busy_n), 32'h0);
      chk("mid_rst_a0", a0_b | a0_n, 32'h0);
      chk("mid_rst_rd", rd_b[2*DW-1:DW] | rd_n[2*DW-1:DW], 32'h0);
      cyc();
      reset = 1'b0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
